// File: rtl/per_pkg.sv
// Shared constants and types for the perceptron training sequencer and its sample store.
package per_pkg;

  localparam int DW    = 16;
  localparam int WAW   = 7;
  localparam int CNT_W = 8;

  localparam logic [3:0] CTL_IDLE  = 4'b0000;
  localparam logic [3:0] CTL_START = 4'b0001;
  localparam logic [3:0] CTL_READ  = 4'b0010;
  localparam logic [3:0] CTL_CALC  = 4'b0100;
  localparam logic [3:0] CTL_UPD   = 4'b1000;

  localparam logic [WAW-1:0] WA_W1 = 7'd0;
  localparam logic [WAW-1:0] WA_W2 = 7'd1;
  localparam logic [WAW-1:0] WA_B  = 7'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_START = 3'd2,
    ST_READ  = 3'd3,
    ST_CALC  = 3'd4,
    ST_UPD   = 3'd5,
    ST_NEXT  = 3'd6,
    ST_DONE  = 3'd7
  } state_t;

  // Phase enable pattern presented to the core while in a given state
  function automatic logic [3:0] phase_ctl(input state_t st);
    case (st)
      ST_START: phase_ctl = CTL_START;
      ST_READ:  phase_ctl = CTL_READ;
      ST_CALC:  phase_ctl = CTL_CALC;
      ST_UPD:   phase_ctl = CTL_UPD;
      default:  phase_ctl = CTL_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/per_sample_ram.sv
// Sample store: one write port, one registered read port; the read register
// holds its value between reads so it can drive the sample outputs directly.
module per_sample_ram
  import per_pkg::*;
#(
  parameter int AW = 11,
  parameter int W  = 3 * DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_r [2**AW];
  logic [W-1:0] rdata_r;

  // Array write; contents are not reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read, cleared by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_r <= '0;
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/per_train_seq.sv
// Training sequencer: owns the weight registers and sample store, and steps the
// perceptron core through start/read/calc/update phases for every sample and epoch.
module per_train_seq
  import per_pkg::*;
#(
  parameter int AW        = 11,
  parameter int EPOCH_W   = 8,
  parameter int DWELL_RD  = 8,
  parameter int DWELL_CAL = 12,
  parameter int UPD_TMO   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [DW-1:0]         load_x1,
  input  logic [DW-1:0]         load_x2,
  input  logic [DW-1:0]         load_label,
  input  logic [AW-1:0]         n_samples,
  input  logic [EPOCH_W-1:0]    n_epochs,
  input  logic                  start,
  output logic [3:0]            control,
  output logic [DW-1:0]         x1_data,
  output logic [DW-1:0]         x2_data,
  output logic [DW-1:0]         label_data,
  input  logic                  w_ena,
  input  logic                  w_we,
  input  logic [WAW-1:0]        w_addr,
  input  logic [DW-1:0]         w_wdata,
  output logic [DW-1:0]         w_rdata,
  output logic                  busy,
  output logic                  done,
  output logic [AW+EPOCH_W-1:0] err_cnt,
  output logic                  timeout
);

  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(DWELL_RD - 1);
  localparam logic [CNT_W-1:0] CAL_LAST = CNT_W'(DWELL_CAL - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(UPD_TMO - 1);

  state_t                 state_r, state_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [AW-1:0]          sample_r, ns_r, load_ptr_r;
  logic [EPOCH_W-1:0]     epoch_r, ne_r;
  logic [DW-1:0]          w1_r, w2_r, b_r, w_rdata_r, rd_mux_s;
  logic [AW+EPOCH_W-1:0]  err_r;
  logic                   timeout_r, we_prev_r;
  logic [3:0]             control_r, control_s;
  logic                   busy_r, busy_s, done_r, done_s, ready_r, ready_s;
  logic                   last_sample_s, last_epoch_s, upd_fall_s, upd_tmo_s, bias_chg_s;

  assign last_sample_s = (sample_r == ns_r);
  assign last_epoch_s  = (epoch_r == ne_r);
  assign upd_fall_s    = we_prev_r & ~w_we;
  assign upd_tmo_s     = (cnt_r == TMO_LAST);
  assign bias_chg_s    = (state_r == ST_UPD) & w_ena & w_we & (w_addr == WA_B) & (w_wdata != b_r);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:  if (start) state_s = ST_FETCH; else state_s = ST_IDLE;
      ST_FETCH: state_s = ST_START;
      ST_START: state_s = ST_READ;
      ST_READ:  if (cnt_r == RD_LAST) state_s = ST_CALC; else state_s = ST_READ;
      ST_CALC:  if (cnt_r == CAL_LAST) state_s = ST_UPD; else state_s = ST_CALC;
      ST_UPD:   if (upd_fall_s || upd_tmo_s) state_s = ST_NEXT; else state_s = ST_UPD;
      ST_NEXT:  if (last_sample_s && last_epoch_s) state_s = ST_DONE; else state_s = ST_FETCH;
      ST_DONE:  state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Outputs decoded from the next state so the registered copies line up with state_r
  always_comb begin
    control_s = phase_ctl(state_s);
    busy_s    = (state_s != ST_IDLE) && (state_s != ST_DONE);
    done_s    = (state_s == ST_DONE);
    ready_s   = (state_s == ST_IDLE);
  end

  // Output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      control_r <= CTL_IDLE;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      ready_r   <= 1'b1;
    end else begin
      control_r <= control_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      ready_r   <= ready_s;
    end
  end

  // Dwell counter, sample/epoch indices, error count and timeout flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r     <= '0;
      sample_r  <= '0;
      epoch_r   <= '0;
      ns_r      <= '0;
      ne_r      <= '0;
      err_r     <= '0;
      timeout_r <= 1'b0;
      we_prev_r <= 1'b0;
    end else begin
      we_prev_r <= w_we;
      cnt_r     <= (state_s != state_r) ? '0 : cnt_r + 1'b1;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            ns_r      <= n_samples;
            ne_r      <= n_epochs;
            sample_r  <= '0;
            epoch_r   <= '0;
            err_r     <= '0;
            timeout_r <= 1'b0;
          end
        end
        ST_UPD: begin
          if (bias_chg_s && (err_r != '1)) begin
            err_r <= err_r + 1'b1;
          end
          // a write-back finishing on the last allowed cycle still counts as on time
          if (upd_tmo_s && !upd_fall_s) begin
            timeout_r <= 1'b1;
          end
        end
        ST_NEXT: begin
          if (last_sample_s) begin
            sample_r <= '0;
            if (!last_epoch_s) begin
              epoch_r <= epoch_r + 1'b1;
            end
          end else begin
            sample_r <= sample_r + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Weight read mux; unmapped addresses read as zero
  always_comb begin
    rd_mux_s = '0;
    case (w_addr)
      WA_W1:   rd_mux_s = w1_r;
      WA_W2:   rd_mux_s = w2_r;
      WA_B:    rd_mux_s = b_r;
      default: rd_mux_s = '0;
    endcase
  end

  // Weight registers; every enabled access also reads, so a write returns the old value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w1_r      <= '0;
      w2_r      <= '0;
      b_r       <= '0;
      w_rdata_r <= '0;
    end else begin
      if (w_ena) begin
        w_rdata_r <= rd_mux_s;
      end
      if (w_ena && w_we) begin
        case (w_addr)
          WA_W1:   w1_r <= w_wdata;
          WA_W2:   w2_r <= w_wdata;
          WA_B:    b_r  <= w_wdata;
          default: ;
        endcase
      end
    end
  end

  // Host load pointer, only live while idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_ptr_r <= '0;
    end else if (state_r == ST_IDLE) begin
      if (start) begin
        load_ptr_r <= '0;
      end else if (load_valid) begin
        load_ptr_r <= load_ptr_r + 1'b1;
      end
    end
  end

  per_sample_ram #(.AW(AW), .W(3 * DW)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (load_valid && (state_r == ST_IDLE)),
    .waddr (load_ptr_r),
    .wdata ({load_x1, load_x2, load_label}),
    .re    (state_r == ST_FETCH),
    .raddr (sample_r),
    .rdata ({x1_data, x2_data, label_data})
  );

  assign control    = control_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign load_ready = ready_r;
  assign w_rdata    = w_rdata_r;
  assign err_cnt    = err_r;
  assign timeout    = timeout_r;

endmodule

// File: tb/tb_per_train_seq.sv
// Directed bench for per_train_seq: weight port, sample load, phase sequencing,
// error counting, update timeout and asynchronous reset in the middle of an update.
module tb_per_train_seq;
  import per_pkg::*;

  localparam int AW = 11;
  localparam int EW = 8;

  logic            clk, rst, load_valid, load_ready, start, w_ena, w_we, busy, done, timeout;
  logic [DW-1:0]   load_x1, load_x2, load_label, x1_data, x2_data, label_data, w_wdata, w_rdata;
  logic [AW-1:0]   n_samples;
  logic [EW-1:0]   n_epochs;
  logic [3:0]      control;
  logic [WAW-1:0]  w_addr;
  logic [AW+EW-1:0] err_cnt;

  int checks = 0;
  int errors = 0;

  logic [15:0] sx1 [4] = '{16'h0100, 16'h0011, 16'hFF00, 16'h1234};
  logic [15:0] sx2 [4] = '{16'h0200, 16'h0022, 16'h0080, 16'h5678};
  logic [15:0] slb [4] = '{16'h0200, 16'h0000, 16'h0200, 16'h0000};

  per_train_seq dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_x1(load_x1), .load_x2(load_x2), .load_label(load_label),
    .n_samples(n_samples), .n_epochs(n_epochs), .start(start), .control(control),
    .x1_data(x1_data), .x2_data(x2_data), .label_data(label_data),
    .w_ena(w_ena), .w_we(w_we), .w_addr(w_addr), .w_wdata(w_wdata), .w_rdata(w_rdata),
    .busy(busy), .done(done), .err_cnt(err_cnt), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one weight-port access and advance to the next falling edge
  task automatic wport(input logic ena, input logic we, input logic [6:0] a, input logic [15:0] d);
    w_ena = ena; w_we = we; w_addr = a; w_wdata = d;
    @(negedge clk);
    w_ena = 1'b0; w_we = 1'b0;
  endtask

  // Run one training pass with an inline core model and phase monitor
  task automatic run_train(input int ns, input int ne, input bit hold_we, input int exp_upd,
                           input bit inject, input logic [15:0] bval);
    int run, starts, busy_cyc, done_cnt, idx, total;
    logic [3:0] prev, ctl;
    bit fin;
    run = 0; starts = 0; busy_cyc = 0; done_cnt = 0; fin = 1'b0; prev = CTL_IDLE;
    total = (ns + 1) * (ne + 1);
    n_samples = AW'(ns);
    n_epochs  = EW'(ne);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ready_busy", 32'(load_ready), 32'd0);
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      ctl = control;
      if (busy) busy_cyc++;
      if (done) begin done_cnt++; fin = 1'b1; end
      if (ctl == prev) begin
        run++;
      end else begin
        case (prev)
          CTL_START: begin chk("start_len", run, 1); chk("start_next", 32'(ctl), 32'(CTL_READ)); end
          CTL_READ:  begin chk("read_len", run, 8);  chk("read_next", 32'(ctl), 32'(CTL_CALC)); end
          CTL_CALC:  begin chk("calc_len", run, 12); chk("calc_next", 32'(ctl), 32'(CTL_UPD)); end
          CTL_UPD:   begin chk("upd_len", run, exp_upd); chk("upd_next", 32'(ctl), 32'(CTL_IDLE)); end
          default: ;
        endcase
        if (ctl == CTL_START) begin
          idx = starts % (ns + 1);
          chk("x1_data", 32'(x1_data), 32'(sx1[idx]));
          chk("x2_data", 32'(x2_data), 32'(sx2[idx]));
          chk("label_data", 32'(label_data), 32'(slb[idx]));
          starts++;
        end
        prev = ctl;
        run = 1;
      end
      if (hold_we) begin
        w_ena = 1'b0; w_we = (ctl == CTL_UPD); w_addr = WA_B; w_wdata = bval;
      end else if (ctl == CTL_UPD && run == 1) begin
        w_ena = 1'b1; w_we = 1'b1; w_addr = WA_B; w_wdata = bval;
      end else begin
        w_ena = 1'b0; w_we = 1'b0;
      end
      if (inject && cyc == 40) begin
        load_valid = 1'b1; load_x1 = 16'hDEAD; load_x2 = 16'hBEEF; load_label = 16'h0200; start = 1'b1;
      end else begin
        load_valid = 1'b0; start = 1'b0;
      end
      if (!fin) @(negedge clk);
    end
    chk("done_seen", 32'(fin), 32'd1);
    chk("done_cnt", done_cnt, 1);
    chk("samples", starts, total);
    chk("busy_cycles", busy_cyc, total * (23 + exp_upd));
    w_ena = 1'b0; w_we = 1'b0;
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
    chk("ready_after", 32'(load_ready), 32'd1);
  endtask

  initial begin
    bit found;
    rst = 1'b0; load_valid = 1'b0; start = 1'b0; w_ena = 1'b0; w_we = 1'b0;
    w_addr = 7'd0; w_wdata = 16'd0; load_x1 = 16'd0; load_x2 = 16'd0; load_label = 16'd0;
    n_samples = '0; n_epochs = '0;
    repeat (3) @(negedge clk);
    chk("rst_control", 32'(control), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rdata", 32'(w_rdata), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_x1", 32'(x1_data), 32'd0);
    chk("rst_label", 32'(label_data), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(load_ready), 32'd1);

    // Weight port
    wport(1'b1, 1'b1, 7'd1, 16'h0100);
    chk("wr1_old", 32'(w_rdata), 32'd0);
    wport(1'b1, 1'b0, 7'd1, 16'h0000);
    chk("rd1", 32'(w_rdata), 32'h0100);
    wport(1'b1, 1'b1, 7'd5, 16'hBEEF);
    chk("rd5_zero", 32'(w_rdata), 32'd0);
    wport(1'b1, 1'b0, 7'd1, 16'h0000);
    chk("rd1_after_w5", 32'(w_rdata), 32'h0100);
    wport(1'b1, 1'b0, 7'd0, 16'h0000);
    chk("rd0_after_w5", 32'(w_rdata), 32'd0);
    wport(1'b1, 1'b0, 7'd2, 16'h0000);
    chk("rd2_after_w5", 32'(w_rdata), 32'd0);
    wport(1'b1, 1'b1, 7'd0, 16'h0AAA);
    chk("rw0_first", 32'(w_rdata), 32'd0);
    wport(1'b1, 1'b1, 7'd0, 16'h0555);
    chk("rw0_old", 32'(w_rdata), 32'h0AAA);
    wport(1'b1, 1'b0, 7'd0, 16'h0000);
    chk("rd0_new", 32'(w_rdata), 32'h0555);
    wport(1'b0, 1'b0, 7'd1, 16'h0000);
    chk("rd_hold", 32'(w_rdata), 32'h0555);

    // Load four samples
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1; load_x1 = sx1[i]; load_x2 = sx2[i]; load_label = slb[i];
      @(negedge clk);
    end
    load_valid = 1'b0;

    // Two epochs of four samples, bias written 0x200 every update, disturbance while busy
    run_train(3, 1, 1'b0, 2, 1'b1, 16'h0200);
    chk("err_after_a", 32'(err_cnt), 32'd1);
    chk("tmo_after_a", 32'(timeout), 32'd0);

    // Core never ends write-back: update times out, run still completes
    run_train(0, 0, 1'b1, 16, 1'b0, 16'h0200);
    chk("tmo_after_b", 32'(timeout), 32'd1);
    chk("err_after_b", 32'(err_cnt), 32'd0);
    wport(1'b1, 1'b0, 7'd2, 16'h0000);
    chk("b_persist", 32'(w_rdata), 32'h0200);

    // Reset in the middle of an update
    n_samples = '0; n_epochs = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (control == CTL_UPD) found = 1'b1;
    end
    chk("upd_reached", 32'(found), 32'd1);
    chk("tmo_cleared", 32'(timeout), 32'd0);
    w_ena = 1'b1; w_we = 1'b1; w_addr = WA_B; w_wdata = 16'h0400;
    @(negedge clk);
    w_ena = 1'b0;
    chk("err_pre_rst", 32'(err_cnt), 32'd1);
    chk("ctl_pre_rst", 32'(control), 32'(CTL_UPD));
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_control", 32'(control), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_err", 32'(err_cnt), 32'd0);
    chk("mid_rst_rdata", 32'(w_rdata), 32'd0);
    @(negedge clk);
    w_we = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    wport(1'b1, 1'b0, 7'd2, 16'h0000);
    chk("b_after_rst", 32'(w_rdata), 32'd0);
    wport(1'b1, 1'b0, 7'd0, 16'h0000);
    chk("w1_after_rst", 32'(w_rdata), 32'd0);
    chk("ready_after_rst", 32'(load_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
